// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and constants for the I2C target endpoint
package i2c_target_pkg;

    localparam int I2C_ADDR_W = 7;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge, START and STOP strobes
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_hist_q, sda_hist_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic scl_s, sda_s, scl_high;

    always_comb begin
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        // Bus conditions only count when SCL was high on both sides of the SDA edge
        scl_high   = scl_s & scl_hist_q;
        scl_rise_d = scl_s & ~scl_hist_q;
        scl_fall_d = ~scl_s & scl_hist_q;
        start_d    = scl_high & sda_hist_q & ~sda_s;
        stop_d     = scl_high & ~sda_hist_q & sda_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise_o  = scl_rise_q;
    assign scl_fall_o  = scl_fall_q;
    assign start_det_o = start_q;
    assign stop_det_o  = stop_q;
    assign sda_o       = sda_hist_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target: address match, write receive, read serve, no clock stretching
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       addressed_o,
    output logic       rw_o
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .sda_o       (sda_s)
    );

    i2c_tgt_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic ack_phase_q, ack_phase_d;
    logic sda_oe_q, sda_oe_d;
    logic rx_valid_q, rx_valid_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic addressed_q, addressed_d;
    logic rw_q, rw_d;
    logic tx_load;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        ack_phase_d = ack_phase_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        rx_valid_d  = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        tx_load     = 1'b0;

        case (state_q)
            IDLE: ;
            ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_d[7:1] == TGT_ADDR) begin
                            rw_d        = shift_d[0];
                            ack_phase_d = 1'b0;
                            state_d     = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
            end
            ADDR_ACK: begin
                // First falling edge starts the ACK bit, the second one ends it
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_oe_d    = 1'b1;
                        addressed_d = 1'b1;
                        ack_phase_d = 1'b1;
                    end else begin
                        ack_phase_d = 1'b0;
                        if (rw_q == RW_WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end else begin
                            tx_load = 1'b1;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = shift_d;
                        rx_valid_d  = 1'b1;
                        ack_phase_d = 1'b0;
                        state_d     = WR_ACK;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_oe_d    = 1'b1;
                        ack_phase_d = 1'b1;
                    end else begin
                        sda_oe_d    = 1'b0;
                        ack_phase_d = 1'b0;
                        state_d     = WR_DATA;
                    end
                end
            end
            RD_DATA: begin
                if (scl_fall) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d    = 1'b0;
                        ack_phase_d = 1'b0;
                        state_d     = RD_ACK;
                    end else begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (sda_s) state_d = IGNORE;
                    else       ack_phase_d = 1'b1;
                end else if (scl_fall && ack_phase_q) begin
                    ack_phase_d = 1'b0;
                    tx_load     = 1'b1;
                end
            end
            IGNORE: sda_oe_d = 1'b0;
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_data_i;
            sda_oe_d   = ~tx_data_i[7];
            bit_cnt_d  = 3'd0;
            state_d    = RD_DATA;
        end

        // Bus conditions override whatever the bit-level logic decided this cycle
        if (stop_det || start_det) begin
            tx_load     = 1'b0;
            rx_valid_d  = 1'b0;
            rx_data_d   = rx_data_q;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = 3'd0;
            stop_d      = stop_det;
            start_d     = start_det;
            state_d     = start_det ? ADDR : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            ack_phase_q <= ack_phase_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign tx_req_o    = tx_load;
    assign start_o     = start_q;
    assign stop_o      = stop_q;
    assign addressed_o = addressed_q;
    assign rw_o        = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench driving the I2C target as a bus controller
module tb_i2c_target;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scl_drv, sda_drv;
    logic       sda_line;
    logic [7:0] tx_data_i;
    logic       sda_oe_o, rx_valid_o, tx_req_o, start_o, stop_o, addressed_o, rw_o;
    logic [7:0] rx_data_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_start, n_stop, n_txreq;
    bit         oe_seen, addr_seen;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    always #5 clk_i = ~clk_i;

    assign sda_line = sda_drv & ~sda_oe_o;

    i2c_target #(.TGT_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scl_i       (scl_drv),
        .sda_i       (sda_line),
        .sda_oe_o    (sda_oe_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .tx_data_i   (tx_data_i),
        .tx_req_o    (tx_req_o),
        .start_o     (start_o),
        .stop_o      (stop_o),
        .addressed_o (addressed_o),
        .rw_o        (rw_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid_o pops one expected byte
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (rx_valid_o) begin
                    if (exp_rx.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no rx_valid", rx_data_o);
                    end else begin
                        check("rx_data", {24'h0, rx_data_o}, {24'h0, exp_rx.pop_front()});
                    end
                end
                if (tx_req_o)    n_txreq++;
                if (start_o)     n_start++;
                if (stop_o)      n_stop++;
                if (sda_oe_o)    oe_seen = 1'b1;
                if (addressed_o) addr_seen = 1'b1;
            end
        end
    end

    // User side of the read path: present the next byte once the current one is taken
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && tx_req_o) begin
                @(posedge clk_i);
                #1;
                tx_data_i = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    task automatic wait_q();
        repeat (8) @(negedge clk_i);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; wait_q();
        scl_drv = 1'b1; wait_q(); wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic clear_counts();
        n_start = 0; n_stop = 0; n_txreq = 0; oe_seen = 1'b0; addr_seen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oe"},    {31'h0, sda_oe_o},    32'h0);
        check({tag, "_rx_data"},   {24'h0, rx_data_o},   32'h0);
        check({tag, "_rx_valid"},  {31'h0, rx_valid_o},  32'h0);
        check({tag, "_tx_req"},    {31'h0, tx_req_o},    32'h0);
        check({tag, "_start"},     {31'h0, start_o},     32'h0);
        check({tag, "_stop"},      {31'h0, stop_o},      32'h0);
        check({tag, "_addressed"}, {31'h0, addressed_o}, 32'h0);
        check({tag, "_rw"},        {31'h0, rw_o},        32'h0);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] got;

        rst_i = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; tx_data_i = 8'h00;
        clear_counts();
        repeat (5) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        wait_q();

        // Write two bytes
        clear_counts();
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        bus_start();
        write_byte(8'h84, ack); check("wr_addr_ack", {31'h0, ack}, 32'h0);
        check("wr_addressed", {31'h0, addressed_o}, 32'h1);
        check("wr_rw", {31'h0, rw_o}, 32'h0);
        write_byte(8'hA5, ack); check("wr_d0_ack", {31'h0, ack}, 32'h0);
        write_byte(8'h3C, ack); check("wr_d1_ack", {31'h0, ack}, 32'h0);
        check("wr_addressed_pre_stop", {31'h0, addressed_o}, 32'h1);
        bus_stop(); wait_q();
        check("wr_addressed_post_stop", {31'h0, addressed_o}, 32'h0);
        check("wr_start_cnt", n_start, 32'd1);
        check("wr_stop_cnt", n_stop, 32'd1);

        // Read two bytes, ACK then NACK
        clear_counts();
        tx_data_i = 8'h5A;
        tx_q.push_back(8'hC3);
        bus_start();
        write_byte(8'h85, ack); check("rd_addr_ack", {31'h0, ack}, 32'h0);
        check("rd_rw", {31'h0, rw_o}, 32'h1);
        read_byte(got, 1'b0); check("rd_byte0", {24'h0, got}, 32'h5A);
        read_byte(got, 1'b1); check("rd_byte1", {24'h0, got}, 32'hC3);
        check("rd_oe_after_nack", {31'h0, sda_oe_o}, 32'h0);
        bus_stop(); wait_q();
        check("rd_txreq_cnt", n_txreq, 32'd2);
        check("rd_stop_cnt", n_stop, 32'd1);

        // Address mismatch
        clear_counts();
        bus_start();
        write_byte(8'h90, ack); check("mm_addr_nack", {31'h0, ack}, 32'h1);
        write_byte(8'h11, ack); check("mm_data_nack", {31'h0, ack}, 32'h1);
        bus_stop(); wait_q();
        check("mm_oe_seen", {31'h0, oe_seen}, 32'h0);
        check("mm_addr_seen", {31'h0, addr_seen}, 32'h0);

        // Repeated START: write then read
        clear_counts();
        exp_rx.push_back(8'h07);
        bus_start();
        write_byte(8'h84, ack); check("rs_wr_addr_ack", {31'h0, ack}, 32'h0);
        write_byte(8'h07, ack); check("rs_wr_data_ack", {31'h0, ack}, 32'h0);
        check("rs_rw_write", {31'h0, rw_o}, 32'h0);
        tx_data_i = 8'h6E;
        bus_rstart();
        write_byte(8'h85, ack); check("rs_rd_addr_ack", {31'h0, ack}, 32'h0);
        check("rs_rw_read", {31'h0, rw_o}, 32'h1);
        read_byte(got, 1'b1); check("rs_rd_byte", {24'h0, got}, 32'h6E);
        bus_stop(); wait_q();
        check("rs_rx_data", {24'h0, rx_data_o}, 32'h07);
        check("rs_start_cnt", n_start, 32'd2);

        // STOP in the middle of a data byte, then a clean write
        clear_counts();
        bus_start();
        write_byte(8'h84, ack); check("sm_addr_ack", {31'h0, ack}, 32'h0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop(); wait_q();
        check("sm_oe", {31'h0, sda_oe_o}, 32'h0);
        check("sm_addressed", {31'h0, addressed_o}, 32'h0);
        exp_rx.push_back(8'h99);
        bus_start();
        write_byte(8'h84, ack); check("sm2_addr_ack", {31'h0, ack}, 32'h0);
        write_byte(8'h99, ack); check("sm2_data_ack", {31'h0, ack}, 32'h0);
        bus_stop(); wait_q();
        check("sm2_rx_data", {24'h0, rx_data_o}, 32'h99);

        // Reset while driving a read byte
        tx_data_i = 8'h00;
        bus_start();
        write_byte(8'h85, ack); check("rst_addr_ack", {31'h0, ack}, 32'h0);
        read_bit(b); read_bit(b);
        check("rst_rd_bit", {31'h0, b}, 32'h0);
        check("rst_oe_before", {31'h0, sda_oe_o}, 32'h1);
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("midrst");
        rst_i = 1'b0;
        bus_stop(); wait_q();

        check("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint. The opposite end of the bus from the team's I2C controller.
- Watches open-drain SCL/SDA and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs write bytes to the user side and serves read bytes from it.
- Used as the DUT-side bus model and as an on-chip register-port front end. It never stretches SCL.

Parameters:
- TGT_ADDR, 7'h42, 7-bit target address compared against the first byte after START.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizer (must be 2 or more).

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pin level (asynchronous).
- sda_i  in  1  SDA pin level (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low; 0 = release (high-Z).
- rx_data_o  out  8  last byte written by the controller.
- rx_valid_o  out  1  1-cycle pulse; rx_data_o is valid.
- tx_data_i  in  8  byte to return on a read; sampled when tx_req_o=1.
- tx_req_o  out  1  1-cycle pulse; the target needs the next read byte.
- start_o  out  1  1-cycle pulse on START or repeated START.
- stop_o  out  1  1-cycle pulse on STOP.
- addressed_o  out  1  high from the address-ACK cycle until STOP or next START.
- rw_o  out  1  R/W bit of the current transfer (1 = read); valid while addressed_o=1.

Behaviour:
- Reset: sda_oe_o=0, all pulses 0, rx_data_o=0, addressed_o=0, rw_o=0, FSM in IDLE, synchronizers preset to 1.
- Input sync: SYNC_STAGES flops per pin, then one history flop; edges are taken from the sync output and the history flop. Detection latency from pin to internal edge is SYNC_STAGES+1 clks.
- START: SDA falls while SCL is high. Pulse start_o, clear the bit counter, go to ADDR from ANY state.
- STOP: SDA rises while SCL is high. Pulse stop_o, sda_oe_o=0, addressed_o=0, go to IDLE from ANY state.
- If START/STOP coincide with an SCL edge in the same cycle, the START/STOP wins.
- Bit timing:
  - SDA is sampled on an internal SCL rising edge; MSB first.
  - SDA changes (sda_oe_o updates) exactly 1 clk after an internal SCL falling edge.
  - SDA never changes while SCL is high.
  - Supported bus: SCL low time ≥ SYNC_STAGES+4 clks.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th rising edge, compare bits[7:1] with TGT_ADDR.
    - Match: latch rw_o, go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: on the falling edge after bit 8, sda_oe_o=1 and addressed_o=1. On the next falling edge (end of the ACK bit):
    - rw=0: sda_oe_o=0, go to WR_DATA.
    - rw=1: tx_req_o pulses on that same clk and tx_data_i is captured; drive the MSB (sda_oe_o = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rising edge, update rx_data_o and pulse rx_valid_o. Go to WR_ACK.
  - WR_ACK: on the falling edge, sda_oe_o=1. On the next falling edge, sda_oe_o=0, go to WR_DATA.
  - RD_DATA: drive bits 6..0 on successive falling edges. After the 8th bit's falling edge, sda_oe_o=0 and go to RD_ACK.
  - RD_ACK: sample the controller's ACK on the rising edge.
    - ACK (0): on the next falling edge, pulse tx_req_o, capture tx_data_i, drive its MSB, go to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: sda_oe_o=0; wait for START/STOP.
- The target always ACKs written bytes. rx_valid_o has no backpressure; the user must absorb it in the same cycle.
- Bit counter is 3 bits; it wraps 7→0 at each byte boundary.
- Reset mid-transfer: immediate IDLE, sda_oe_o released next clk. Bus traffic before the next START is ignored.

Decomposition:
- Package i2c_target_pkg holds:
  - state enum i2c_tgt_state_e (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - localparam I2C_ADDR_W=7;
  - R/W encoding constants.
- One sub-module, i2c_bus_sync: pin synchronizer plus edge/condition detector. It outputs scl_rise, scl_fall, start_det and stop_det as 1-cycle strobes.

Test Plan:
- Write: START, 0x84 (addr 0x42, W), data 0xA5, 0x3C, STOP → ACK on all 3 bytes. rx_valid_o pulses twice with 0xA5 then 0x3C. start_o and stop_o pulse once each. addressed_o falls at STOP.
- Read: START, 0x85, tx_data_i=0x5A then 0xC3, controller ACKs byte 1 and NACKs byte 2, STOP → SDA shows 0x5A then 0xC3; tx_req_o pulses exactly twice; sda_oe_o=0 after the NACK.
- Address mismatch: START, 0x90, 0x11, STOP → sda_oe_o stays 0 throughout; no rx_valid_o; addressed_o stays 0.
- Repeated START: START, 0x84, 0x07, rSTART, 0x85, read 1 byte with NACK, STOP → rx_data_o=0x07; rw_o goes 0→1; start_o pulses twice.
- STOP mid-byte: START, 0x84, 4 data bits, STOP → FSM returns to IDLE; no rx_valid_o; sda_oe_o=0. A following valid write of 0x99 is received correctly.
- Reset during RD_DATA while sda_oe_o=1 → sda_oe_o=0 within 1 clk after rst_i. All outputs match their reset values.
